// File: rtl/inst_loader.sv
// Byte-serial program loader: assembles little-endian words from a byte
// stream and strobes them into instruction memory while holding the CPU.
module inst_loader #(
   parameter int MEM_WORDS = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             write_enable,
   output logic [31:0]      tb_addr,
   output logic [31:0]      tb_inst,
   output logic             cpu_hold,
   output logic             done,
   output logic             error
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MEM_WORDS);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [1:0]       bcnt_q, bcnt_d;
   logic [23:0]      asm_q, asm_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      inst_q, inst_d;
   logic             err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         num_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         asm_q   <= '0;
         addr_q  <= '0;
         inst_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         addr_q  <= addr_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      num_d        = num_q;
      idx_d        = idx_q;
      bcnt_d       = bcnt_q;
      asm_d        = asm_q;
      addr_d       = addr_q;
      inst_d       = inst_q;
      err_d        = err_q;
      byte_ready   = 1'b0;
      write_enable = 1'b0;
      cpu_hold     = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (num_words == '0) begin
                  state_d = DONE;
                  err_d   = 1'b0;
               end else if (num_words > MAX_N) begin
                  state_d = DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = RECV;
                  num_d   = num_words;
                  idx_d   = '0;
                  bcnt_d  = '0;
                  err_d   = 1'b0;
               end
            end
         end
         RECV: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (byte_valid) begin
               bcnt_d = bcnt_q + 2'd1;
               // Last byte goes straight into the output word with the
               // three buffered ones so tb_inst only changes on WRITE entry.
               if (bcnt_q == 2'd3) begin
                  inst_d  = {byte_data, asm_q};
                  addr_d  = {{(30-CNT_W){1'b0}}, idx_q, 2'b00};
                  state_d = WRITE;
               end else begin
                  asm_d[8*bcnt_q +: 8] = byte_data;
               end
            end
         end
         WRITE: begin
            write_enable = 1'b1;
            cpu_hold     = 1'b1;
            idx_d        = idx_q + CNT_W'(1);
            bcnt_d       = '0;
            if (idx_q + CNT_W'(1) == num_q) begin
               state_d = DONE;
            end else begin
               state_d = RECV;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tb_addr = addr_q;
   assign tb_inst = inst_q;
   assign done    = (state_q == DONE) && !err_q;
   assign error   = err_q;

endmodule
